dbg_ins_encoder: RTL



---
 rtl/dbg_ins_encoder_pkg.sv | 43 ++++
 rtl/dbg_ins_encoder_if.sv | 31 +++
 rtl/dbg_ins_encoder_rv_ins_pack.sv | 26 ++
 rtl/dbg_ins_encoder.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/dbg_ins_encoder_pkg.sv
// Shared pipeline constants for the debug instruction encoder:
// RV32I opcodes/funct3, command op codes and FSM state encoding.
package dbg_ins_encoder_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_ADDI  = 3'b000;
  localparam logic [2:0] F3_CSRRW = 3'b001;
  localparam logic [2:0] F3_CSRRS = 3'b010;

  localparam logic [11:0] DEF_DSCRATCH_ADDR = 12'h7B2;
  localparam logic [4:0]  DEF_SCRATCH_REG   = 5'd5;

  typedef enum logic [1:0] {
    OP_REG_RD = 2'd0,
    OP_REG_WR = 2'd1,
    OP_CSR_RD = 2'd2,
    OP_CSR_WR = 2'd3
  } cmd_op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_EMIT = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    FMT_U   = 2'd0,
    FMT_I   = 2'd1,
    FMT_CSR = 2'd2
  } fmt_e;

  // Rounded upper part so that LUI + sign-extended ADDI rebuilds data.
  function automatic logic [19:0] hi20(
    input logic [31:0] d
  );
    logic [31:0] s;
    s = d + 32'h0000_0800;
    return s[31:12];
  endfunction

endpackage

// File: rtl/dbg_ins_encoder_if.sv
// Debug command port and instruction-injection port,
// with valid/ready handshakes plus abort/done/err sidebands.
interface dbg_ins_encoder_if;

  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [11:0] cmd_regno;
  logic [31:0] cmd_data;
  logic        abort;
  logic        ins_valid;
  logic        ins_ready;
  logic [31:0] ins;
  logic        done;
  logic        err;

  modport master (
    output cmd_valid, cmd_op, cmd_regno,
    output cmd_data, abort, ins_ready,
    input  cmd_ready, ins_valid, ins,
    input  done, err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_regno,
    input  cmd_data, abort, ins_ready,
    output cmd_ready, ins_valid, ins,
    output done, err
  );

endinterface

// File: rtl/dbg_ins_encoder_rv_ins_pack.sv
// Combinational packer for RV32I U-type, I-type
// and CSR-type instruction words from their fields.
module rv_ins_pack
  import dbg_ins_encoder_pkg::*;
(
  input  fmt_e        fmt,
  input  logic [6:0]  opc,
  input  logic [2:0]  f3,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [19:0] imm20,
  input  logic [11:0] imm12,
  output logic [31:0] word
);

  always_comb begin
    word = '0;
    unique case (1'b1)
      fmt == FMT_U:   word = {imm20, rd, opc};
      fmt == FMT_I:   word = {imm12, rs1, f3, rd, opc};
      fmt == FMT_CSR: word = {imm12, rs1, f3, rd, opc};
      default:        word = '0;
    endcase
  end

endmodule

// File: rtl/dbg_ins_encoder.sv
// Encodes abstract debug GPR/CSR commands into RV32I
// instruction sequences fed to the fetch injection path.
module dbg_ins_encoder
  import dbg_ins_encoder_pkg::*;
#(
  parameter logic [11:0] DSCRATCH_ADDR = DEF_DSCRATCH_ADDR,
  parameter logic [4:0]  SCRATCH_REG   = DEF_SCRATCH_REG
) (
  input  logic              clk,
  input  logic              rst,
  dbg_ins_encoder_if.slave  bus
);

  state_e      state;
  logic [1:0]  step;
  cmd_op_e     op;
  logic [11:0] regno;
  logic [31:0] data;

  logic        ins_valid;
  logic [31:0] ins;
  logic        cmd_ready;
  logic        done;
  logic        err;

  fmt_e        fmt;
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [19:0] imm20;
  logic [11:0] imm12;
  logic [31:0] word;
  logic        last;

  cmd_op_e     in_op;
  logic        in_bad;
  logic        in_nop;

  assign in_op  = cmd_op_e'(bus.cmd_op);
  assign in_bad = !in_op[1] && (|bus.cmd_regno[11:5]);
  assign in_nop = (in_op == OP_REG_WR) &&
                  (bus.cmd_regno[4:0] == 5'd0);

  always_comb begin
    fmt   = FMT_CSR;
    opc   = OPC_SYSTEM;
    f3    = F3_CSRRW;
    rd    = 5'd0;
    rs1   = 5'd0;
    imm20 = hi20(data);
    imm12 = DSCRATCH_ADDR;
    last  = 1'b0;
    unique case (op)
      OP_REG_RD: begin
        rs1  = regno[4:0];
        last = 1'b1;
      end
      OP_REG_WR: begin
        rd   = regno[4:0];
        last = (step == 2'd1);
        if (step == 2'd0) begin
          fmt = FMT_U;
          opc = OPC_LUI;
        end else begin
          fmt   = FMT_I;
          opc   = OPC_OP_IMM;
          f3    = F3_ADDI;
          rs1   = regno[4:0];
          imm12 = data[11:0];
        end
      end
      OP_CSR_RD: begin
        last = (step == 2'd1);
        if (step == 2'd0) begin
          f3    = F3_CSRRS;
          rd    = SCRATCH_REG;
          imm12 = regno;
        end else begin
          rs1 = SCRATCH_REG;
        end
      end
      OP_CSR_WR: begin
        last = (step == 2'd2);
        unique case (step)
          2'd0: begin
            fmt = FMT_U;
            opc = OPC_LUI;
            rd  = SCRATCH_REG;
          end
          2'd1: begin
            fmt   = FMT_I;
            opc   = OPC_OP_IMM;
            f3    = F3_ADDI;
            rd    = SCRATCH_REG;
            rs1   = SCRATCH_REG;
            imm12 = data[11:0];
          end
          default: begin
            rs1   = SCRATCH_REG;
            imm12 = regno;
          end
        endcase
      end
      default: last = 1'b1;
    endcase
  end

  rv_ins_pack u_pack (
    .fmt   (fmt),
    .opc   (opc),
    .f3    (f3),
    .rd    (rd),
    .rs1   (rs1),
    .imm20 (imm20),
    .imm12 (imm12),
    .word  (word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      step      <= 2'd0;
      op        <= OP_REG_RD;
      regno     <= '0;
      data      <= '0;
      ins_valid <= 1'b0;
      ins       <= '0;
      cmd_ready <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (!bus.abort && bus.cmd_valid) begin
            op    <= in_op;
            regno <= bus.cmd_regno;
            data  <= bus.cmd_data;
            step  <= 2'd0;
            if (in_bad) begin
              err <= 1'b1;
            end else if (in_nop) begin
              done <= 1'b1;
            end else begin
              state     <= S_EMIT;
              cmd_ready <= 1'b0;
            end
          end
        end
        S_EMIT: begin
          // Abort wins over a coincident final handshake.
          if (bus.abort) begin
            ins_valid <= 1'b0;
            state     <= S_IDLE;
            cmd_ready <= 1'b1;
          end else if (ins_valid) begin
            if (bus.ins_ready) begin
              ins_valid <= 1'b0;
              if (last) begin
                state     <= S_IDLE;
                cmd_ready <= 1'b1;
                done      <= 1'b1;
              end else begin
                step <= step + 2'd1;
              end
            end
          end else begin
            ins       <= word;
            ins_valid <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = cmd_ready;
  assign bus.ins_valid = ins_valid;
  assign bus.ins       = ins;
  assign bus.done      = done;
  assign bus.err       = err;

endmodule
